// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   - arb_state_e : arbiter phase (running, draining, drained)
//   - PORT_*      : requester index assignment
//   - rd_tag_t    : read-return tag carried through the latency pipeline
package sram_arb_pkg;

  // Width of the port id in a read tag; covers up to four requesters.
  localparam int ID_W = 2;

  localparam int PORT_VGA  = 0;
  localparam int PORT_UART = 1;
  localparam int PORT_DEC  = 2;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DRAIN   = 2'd1,
    S_FLUSHED = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector (bit 0 is the lowest-numbered shared port)
//   start_i : index to start searching from; search wraps past the top
//   gnt_o   : one-hot grant, zero when nothing requests
module sram_arb_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic [N-1:0]  gnt_o
);

  logic found;

  // Two passes: first from start_i to the top, then wrap from 0 to start_i-1.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && (i >= int'(start_i)) && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && (i < int'(start_i)) && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external SRAM port between NUM_PORTS requesters.
// Port 0 (VGA fetch) has strict priority, bounded by MAX_HOG consecutive
// grants while others wait; the remaining ports share round-robin.
//
// Handshake: a requester raises req_i with stable addr/we_n/wdata and holds
// them until it sees gnt_o high; gnt_o is combinational and the access is
// accepted on the clock edge ending that cycle. A port may re-request the
// very next cycle.
//
// Ports:
//   Clock_50, Resetn          : clock, async active-low reset
//   req_i/we_n_i/addr_i/wdata_i: per-port request (we_n low = write)
//   gnt_o                     : one-hot combinational grant
//   rvalid_o/rdata_o          : read return, READ_LATENCY cycles after grant
//   flush_req_i/flushed_o     : drain handshake for phase changes
//   SRAM_*                    : registered controller interface
//   dbg_state_o/dbg_rr_ptr_o  : phase and round-robin pointer for observation
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int READ_LATENCY = 3,
  parameter int MAX_HOG      = 7,
  localparam int PTR_W       = $clog2(NUM_PORTS)
) (
  input  logic                        Clock_50,
  input  logic                        Resetn,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        we_n_i,
  input  logic [NUM_PORTS-1:0][17:0]  addr_i,
  input  logic [NUM_PORTS-1:0][15:0]  wdata_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [NUM_PORTS-1:0]        rvalid_o,
  output logic [15:0]                 rdata_o,
  input  logic                        flush_req_i,
  output logic                        flushed_o,
  output logic [17:0]                 SRAM_address,
  output logic [15:0]                 SRAM_write_data,
  output logic                        SRAM_we_n,
  input  logic [15:0]                 SRAM_read_data,
  output arb_state_e                  dbg_state_o,
  output logic [PTR_W-1:0]            dbg_rr_ptr_o
);

  localparam int RR_W  = (NUM_PORTS > 2) ? $clog2(NUM_PORTS-1) : 1;
  localparam int HOG_W = $clog2(MAX_HOG + 1);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;   // holds a port number, 1..NUM_PORTS-1
  logic [HOG_W-1:0]    hog_q, hog_d;
  logic [17:0]         addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                we_n_q, we_n_d;
  rd_tag_t             tag_q [READ_LATENCY];
  rd_tag_t             tag_d [READ_LATENCY];

  logic                others_req;
  logic                grant_en;
  logic                vga_win;
  logic                any_gnt;
  logic                inflight;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-2:0] rr_gnt;
  logic [RR_W-1:0]     rr_start;
  logic [ID_W-1:0]     gnt_id;

  // Picker works on ports 1..NUM_PORTS-1, so its index is port number - 1.
  assign rr_start = RR_W'(rr_ptr_q - PTR_W'(1));

  sram_arb_rr_pick #(
    .N  (NUM_PORTS-1),
    .PW (RR_W)
  ) u_rr_pick (
    .req_i   (req_i[NUM_PORTS-1:1]),
    .start_i (rr_start),
    .gnt_o   (rr_gnt)
  );

  // Grant selection. The cycle flush is first seen is already grant-free.
  always_comb begin
    others_req = |req_i[NUM_PORTS-1:1];
    grant_en   = (state_q == S_RUN) && !flush_req_i;
    vga_win    = req_i[PORT_VGA] && ((hog_q < HOG_W'(MAX_HOG)) || !others_req);
    gnt        = '0;
    if (grant_en) begin
      if (vga_win) gnt[PORT_VGA] = 1'b1;
      else         gnt[NUM_PORTS-1:1] = rr_gnt;
    end
    any_gnt = |gnt;
    gnt_id  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (gnt[k]) gnt_id = ID_W'(k);
    end
  end

  assign gnt_o = gnt;

  // Issue register, hog counter and round-robin pointer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    hog_d    = hog_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_n_d   = 1'b1;
    if (any_gnt) begin
      addr_d  = addr_i[gnt_id];
      wdata_d = wdata_i[gnt_id];
      we_n_d  = we_n_i[gnt_id];
      if (gnt[PORT_VGA]) begin
        // Only counts while someone else is being held off.
        hog_d = others_req ? (hog_q + HOG_W'(1)) : '0;
      end else begin
        hog_d    = '0;
        rr_ptr_d = (gnt_id == ID_W'(NUM_PORTS-1)) ? PTR_W'(PORT_UART)
                                                  : (PTR_W'(gnt_id) + PTR_W'(1));
      end
    end
  end

  // Read tag pipeline; the last stage lines up with SRAM_read_data.
  always_comb begin
    tag_d[0].valid = any_gnt && we_n_i[gnt_id];
    tag_d[0].id    = gnt_id;
    for (int i = 1; i < READ_LATENCY; i++) tag_d[i] = tag_q[i-1];
    // Valid tags that will still be in the pipe after the next edge.
    inflight = 1'b0;
    for (int i = 0; i < READ_LATENCY-1; i++) inflight = inflight | tag_q[i].valid;
  end

  always_comb begin
    rvalid_o = '0;
    if (tag_q[READ_LATENCY-1].valid) rvalid_o[tag_q[READ_LATENCY-1].id] = 1'b1;
  end

  assign rdata_o = SRAM_read_data;

  // Phase FSM. Draining ends once the last read is on its final stage, so
  // flushed_o rises the cycle after the last rvalid pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:     if (flush_req_i) state_d = S_DRAIN;
      S_DRAIN:   if (!inflight) state_d = flush_req_i ? S_FLUSHED : S_RUN;
      S_FLUSHED: if (!flush_req_i) state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_RUN;
      rr_ptr_q <= PTR_W'(PORT_UART);
      hog_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_n_q   <= 1'b1;
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      hog_q    <= hog_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_n_q   <= we_n_d;
      tag_q    <= tag_d;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign flushed_o       = (state_q == S_FLUSHED);
  assign dbg_state_o     = state_q;
  assign dbg_rr_ptr_o    = rr_ptr_q;

  // A grant only ever goes to a requesting port, and to at most one.
  a_gnt_has_req: assert property (@(posedge Clock_50) disable iff (!Resetn)
                                  (gnt & ~req_i) == '0);
  a_gnt_onehot:  assert property (@(posedge Clock_50) disable iff (!Resetn)
                                  $onehot0(gnt));

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int NP      = 3;
  localparam int RL      = 3;
  localparam int MAX_HOG = 7;
  localparam int M_RUN = 0, M_DRAIN = 1, M_FLUSHED = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic Resetn = 1'b0;
  always #10 clk = ~clk;

  logic [NP-1:0]       req_i, we_n_i, gnt_o, rvalid_o;
  logic [NP-1:0][17:0] addr_i;
  logic [NP-1:0][15:0] wdata_i;
  logic [15:0]         rdata_o;
  logic                flush_req_i, flushed_o;
  logic [17:0]         SRAM_address;
  logic [15:0]         SRAM_write_data, SRAM_read_data;
  logic                SRAM_we_n;
  arb_state_e          dbg_state;
  logic [1:0]          dbg_rr_ptr;

  sram_arbiter #(.NUM_PORTS(NP), .READ_LATENCY(RL), .MAX_HOG(MAX_HOG)) dut (
    .Clock_50(clk), .Resetn(Resetn),
    .req_i(req_i), .we_n_i(we_n_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .flush_req_i(flush_req_i), .flushed_o(flushed_o),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_rr_ptr)
  );

  // SRAM controller model: read data appears two edges after the address.
  function automatic logic [9:0] mem_idx(input logic [17:0] a);
    return {a[17:16], a[7:0]};
  endfunction

  logic [15:0] sram_mem [0:1023];
  logic [15:0] rd_d1;
  always @(posedge clk) begin
    if (!SRAM_we_n) sram_mem[mem_idx(SRAM_address)] <= SRAM_write_data;
    rd_d1          <= sram_mem[mem_idx(SRAM_address)];
    SRAM_read_data <= rd_d1;
  end

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [49:0] exp_q[$];           // {due cycle[31:0], port[1:0], data[15:0]}
  logic [15:0] exp_mem [0:1023];
  int          m_st, m_ptr, m_hog;
  logic        m_we_n;
  logic [17:0] m_addr;
  logic [15:0] m_wdata;

  // stimulus for the next cycle and what was observed
  logic [NP-1:0]       t_req, t_wen, got;
  logic [NP-1:0][17:0] t_a;
  logic [NP-1:0][15:0] t_d;
  logic                t_flush;
  logic [NP-1:0]       seen_rvalid;
  logic [15:0]         seen_rdata;
  logic                seen_flushed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_st = M_RUN; m_ptr = 1; m_hog = 0;
    m_we_n = 1'b1; m_addr = '0; m_wdata = '0;
  endtask

  // Which port the rules say wins this cycle, -1 for none.
  function automatic int model_pick();
    int p;
    if (m_st != M_RUN || t_flush) return -1;
    if (t_req[0] && (m_hog < MAX_HOG || t_req[NP-1:1] == '0)) return 0;
    for (int i = 0; i < NP-1; i++) begin
      p = 1 + ((m_ptr - 1 + i) % (NP - 1));
      if (t_req[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic pending_after(input int c);
    foreach (exp_q[i]) if (int'(exp_q[i][49:18]) > c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input int p);
    logic others;
    others = |t_req[NP-1:1];
    m_we_n = 1'b1;
    if (p >= 0) begin
      m_we_n = t_wen[p]; m_addr = t_a[p]; m_wdata = t_d[p];
      if (!t_wen[p]) exp_mem[mem_idx(t_a[p])] = t_d[p];
      else exp_q.push_back({32'(cyc + RL), 2'(p), exp_mem[mem_idx(t_a[p])]});
      if (p == 0) m_hog = others ? m_hog + 1 : 0;
      else begin
        m_hog = 0;
        m_ptr = (p == NP-1) ? 1 : p + 1;
      end
    end
    case (m_st)
      M_RUN:     if (t_flush) m_st = M_DRAIN;
      M_DRAIN:   if (!pending_after(cyc)) m_st = t_flush ? M_FLUSHED : M_RUN;
      default:   if (!t_flush) m_st = M_RUN;
    endcase
  endtask

  task automatic check_outputs();
    logic [NP-1:0] exp_rv;
    logic [49:0]   e;
    exp_rv = '0;
    if (exp_q.size() > 0 && int'(exp_q[0][49:18]) == cyc) begin
      e = exp_q.pop_front();
      exp_rv = 3'b001 << e[17:16];
      check("rdata", 32'(rdata_o), 32'(e[15:0]));
    end
    check("rvalid", 32'(rvalid_o), 32'(exp_rv));
    check("sram_we_n", 32'(SRAM_we_n), 32'(m_we_n));
    check("sram_addr", 32'(SRAM_address), 32'(m_addr));
    check("sram_wdata", 32'(SRAM_write_data), 32'(m_wdata));
    check("flushed", 32'(flushed_o), 32'(m_st == M_FLUSHED));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_cycle();
    int p;
    logic [NP-1:0] exp_g;
    @(negedge clk);
    cyc++;
    seen_rvalid = rvalid_o; seen_rdata = rdata_o; seen_flushed = flushed_o;
    check_outputs();
    req_i = t_req; we_n_i = t_wen; addr_i = t_a; wdata_i = t_d; flush_req_i = t_flush;
    #1;
    got = gnt_o;
    p = model_pick();
    exp_g = (p < 0) ? 3'b000 : 3'(1 << p);
    check("gnt", 32'(gnt_o), 32'(exp_g));
    model_update(p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    t_req = '0; t_flush = 1'b0; req_i = '0; flush_req_i = 1'b0;
    Resetn = 1'b0;
    #1;
    check("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check("rst_addr", 32'(SRAM_address), 32'd0);
    check("rst_wdata", 32'(SRAM_write_data), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_flushed", 32'(flushed_o), 32'd0);
    check("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(S_RUN));
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    model_reset();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] exp_gnt;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] pend, stale;
    int n;
    int rate [4][NP] = '{'{90, 90, 90}, '{100, 30, 30}, '{0, 80, 80}, '{40, 40, 40}};
    for (int i = 0; i < 1024; i++) begin sram_mem[i] = '0; exp_mem[i] = '0; end
    req_i = '0; we_n_i = '1; addr_i = '0; wdata_i = '0; flush_req_i = 1'b0;
    t_req = '0; t_wen = '1; t_a = '0; t_d = '0; t_flush = 1'b0;
    model_reset();
    do_reset();

    // Port 1 alone: four writes then four reads.
    for (int i = 0; i < 4; i++) begin
      t_req = 3'b010; t_wen = 3'b101; t_a[1] = 18'(i); t_d[1] = 16'h1000 + 16'(i);
      do_cycle();
      check("t1_wr_gnt", 32'(got), 32'b010);
    end
    for (int i = 0; i < 4; i++) begin
      t_req = 3'b010; t_wen = 3'b111; t_a[1] = 18'(i);
      do_cycle();
      check("t1_rd_gnt", 32'(got), 32'b010);
    end
    t_req = '0;
    repeat (4) do_cycle();

    // Table: idle, 1/2 alternation, port-0 hog bound, single-requester cases.
    do_reset();
    vecs.push_back('{3'b000, 3'b000});
    for (int i = 0; i < 4; i++) vecs.push_back('{3'b110, (i % 2 == 0) ? 3'b010 : 3'b100});
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < MAX_HOG; i++) vecs.push_back('{3'b101, 3'b001});
      vecs.push_back('{3'b101, 3'b100});
    end
    vecs.push_back('{3'b001, 3'b001});
    vecs.push_back('{3'b011, 3'b001});
    vecs.push_back('{3'b010, 3'b010});
    vecs.push_back('{3'b100, 3'b100});
    vecs.push_back('{3'b000, 3'b000});
    t_wen = 3'b111;
    for (int p = 0; p < NP; p++) t_a[p] = 18'h00040 + 18'(p);
    for (int i = 0; i < vecs.size(); i++) begin
      t_req = vecs[i].req;
      do_cycle();
      check("table_gnt", 32'(got), 32'(vecs[i].exp_gnt));
    end

    // Preload three words, then read them back from ports 0,1,2.
    t_a[0] = 18'h10; t_a[1] = 18'h20; t_a[2] = 18'h30;
    t_d[0] = 16'hAAAA; t_d[1] = 16'hBBBB; t_d[2] = 16'hCCCC;
    t_req = 3'b001; t_wen = 3'b110; do_cycle();
    t_req = 3'b010; t_wen = 3'b101; do_cycle();
    t_req = 3'b100; t_wen = 3'b011; do_cycle();
    t_wen = 3'b111;
    t_req = 3'b111; do_cycle(); check("t4_gnt0", 32'(got), 32'b001);
    t_req = 3'b110; do_cycle(); check("t4_gnt1", 32'(got), 32'b010);
    t_req = 3'b100; do_cycle(); check("t4_gnt2", 32'(got), 32'b100);
    t_req = 3'b000;
    do_cycle(); check("t4_rv0", 32'(seen_rvalid), 32'b001); check("t4_rd0", 32'(seen_rdata), 32'hAAAA);
    do_cycle(); check("t4_rv1", 32'(seen_rvalid), 32'b010); check("t4_rd1", 32'(seen_rdata), 32'hBBBB);
    do_cycle(); check("t4_rv2", 32'(seen_rvalid), 32'b100); check("t4_rd2", 32'(seen_rdata), 32'hCCCC);

    // Flush with three reads in flight.
    for (int i = 0; i < 3; i++) begin
      t_req = 3'b010; t_a[1] = 18'h20 + 18'(i); do_cycle();
    end
    t_req = 3'b010; t_a[1] = 18'h23; t_flush = 1'b1;
    do_cycle(); check("t5_no_gnt_first", 32'(got), 32'd0);
    n = 0;
    do begin
      do_cycle(); n++;
      check("t5_no_gnt_drain", 32'(got), 32'd0);
    end while (!seen_flushed && n < 10);
    check("t5_flush_latency", 32'(n), 32'd3);
    t_flush = 1'b0;
    do_cycle();
    check("t5_flushed_still", 32'(seen_flushed), 32'd1);
    check("t5_no_gnt_release", 32'(got), 32'd0);
    do_cycle();
    check("t5_flushed_low", 32'(seen_flushed), 32'd0);
    check("t5_gnt_resume", 32'(got), 32'b010);
    t_req = '0;
    repeat (4) do_cycle();

    // Reset with two reads in flight; pointer left at 2 beforehand.
    t_req = 3'b100; t_a[2] = 18'h30; do_cycle();
    t_req = 3'b010; t_a[1] = 18'h20; do_cycle();
    do_reset();
    stale = '0;
    repeat (5) begin do_cycle(); stale = stale | seen_rvalid; end
    check("t6_no_stale_rvalid", 32'(stale), 32'd0);
    t_req = 3'b110; do_cycle(); check("t6_ptr_after_reset", 32'(got), 32'b010);
    t_req = 3'b100; do_cycle();
    t_req = '0; repeat (4) do_cycle();

    // Randomized traffic against the reference model.
    pend = '0;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 100; k++) begin
        for (int p = 0; p < NP; p++) begin
          if (!pend[p] && $urandom_range(0, 99) < rate[s][p]) begin
            pend[p]  = 1'b1;
            t_wen[p] = 1'($urandom_range(0, 1));
            t_a[p]   = {2'($urandom_range(0, 3)), 8'h00, 8'($urandom_range(0, 15))};
            t_d[p]   = 16'($urandom);
          end
        end
        t_req = pend;
        do_cycle();
        pend = pend & ~got;
      end
    end
    t_req = '0;
    repeat (6) do_cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("port_dec_index", 32'(PORT_DEC), 32'(NP - 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
